// File: rtl/async_fifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer controllers.
// Holds the default address width, the pointer width and the Gray conversion helpers.
package async_fifo_pkg;

   localparam int ADDR_W_DEFAULT = 4;
   localparam int PTR_W_DEFAULT  = ADDR_W_DEFAULT + 1;

   // The conversions work on a wide container. Callers zero-extend into it
   // and truncate the result, so one function serves every pointer width.
   localparam int FN_W = 32;
   typedef logic [FN_W-1:0] ptr_fn_t;

   function automatic ptr_fn_t bin2gray(input ptr_fn_t b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down. Zero upper bits leave the low bits unchanged.
   function automatic ptr_fn_t gray2bin(input ptr_fn_t g);
      ptr_fn_t b;
      b[FN_W-1] = g[FN_W-1];
      for (int i = FN_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterized-width two-flop synchronizer with asynchronous active-high reset.
// The read-side pointer controller reuses this module.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             CLK_i,
   input  logic             RST_i,
   input  logic [WIDTH-1:0] D_i,
   output logic [WIDTH-1:0] Q_o
);

   logic [WIDTH-1:0] rq1_q;
   logic [WIDTH-1:0] rq2_q;

   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         rq1_q <= '0;
         rq2_q <= '0;
      end else begin
         rq1_q <= D_i;
         rq2_q <= rq1_q;
      end
   end

   assign Q_o = rq2_q;

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer controller for the asynchronous FIFO: binary/Gray write pointer,
// read-pointer synchronizer and a registered full flag. Optional almost-full: WPTR_ALMOST_FULL_EN.
module fifo_wptr_ctrl
   import async_fifo_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT
`ifdef WPTR_ALMOST_FULL_EN
   ,
   parameter int AF_MARGIN = 2
`endif
) (
   input  logic              CLK_i,
   input  logic              RST_i,
   input  logic              WINC_i,
   input  logic [ADDR_W:0]   RGRAY_i,
   output logic              WEN_o,
   output logic [ADDR_W-1:0] WADDR_o,
   output logic [ADDR_W:0]   WGRAY_o,
   output logic              WFULL_o
`ifdef WPTR_ALMOST_FULL_EN
   ,
   output logic              AFULL_o
`endif
);

   localparam int PW = ADDR_W + 1;

   logic [PW-1:0] wbin_q;
   logic [PW-1:0] wbin_d;
   logic [PW-1:0] wgray_q;
   logic [PW-1:0] wgray_d;
   logic [PW-1:0] rq2;
   logic [PW-1:0] full_cmp;
   logic          wfull_q;
   logic          wfull_d;

   // RGRAY_i is asynchronous; only the synchronized copy is ever used.
   sync_2ff #(
      .WIDTH (PW)
   ) u_rsync (
      .CLK_i (CLK_i),
      .RST_i (RST_i),
      .D_i   (RGRAY_i),
      .Q_o   (rq2)
   );

   // Write handshake: WINC_i is a request, WEN_o the same-cycle acceptance;
   // a request is accepted unless full, and a refused request is simply dropped.
   assign WEN_o = WINC_i & ~wfull_q;

   always_comb begin
      wbin_d   = wbin_q + {{ADDR_W{1'b0}}, WEN_o};
      wgray_d  = PW'(bin2gray(ptr_fn_t'(wbin_d)));
      full_cmp = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
      wfull_d  = (wgray_d == full_cmp);
   end

   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         wfull_q <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         wfull_q <= wfull_d;
      end
   end

   assign WADDR_o = wbin_q[ADDR_W-1:0];
   assign WGRAY_o = wgray_q;
   assign WFULL_o = wfull_q;

`ifdef WPTR_ALMOST_FULL_EN
   localparam logic [PW-1:0] AF_THRESH = PW'((1 << ADDR_W) - AF_MARGIN);

   logic [PW-1:0] rbin;
   logic [PW-1:0] level;
   logic          afull_q;
   logic          afull_d;

   // Level uses the post-write pointer so almost-full lines up with full.
   always_comb begin
      rbin    = PW'(gray2bin(ptr_fn_t'(rq2)));
      level   = wbin_d - rbin;
      afull_d = (level >= AF_THRESH);
   end

   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         afull_q <= 1'b0;
      end else begin
         afull_q <= afull_d;
      end
   end

   assign AFULL_o = afull_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Self-checking bench for fifo_wptr_ctrl with ADDR_W=4 (almost-full checks when WPTR_ALMOST_FULL_EN).
module tb_fifo_wptr_ctrl;
  localparam int AW = 4;

  logic          CLK_i = 1'b0;
  logic          RST_i = 1'b0;
  logic          WINC_i = 1'b0;
  logic [AW:0]   RGRAY_i = '0;
  logic          WEN_o;
  logic [AW-1:0] WADDR_o;
  logic [AW:0]   WGRAY_o;
  logic          WFULL_o;
`ifdef WPTR_ALMOST_FULL_EN
  logic          AFULL_o;
`endif

  logic run_clk = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr;

  fifo_wptr_ctrl #(.ADDR_W(AW)) dut (
    .CLK_i   (CLK_i),
    .RST_i   (RST_i),
    .WINC_i  (WINC_i),
    .RGRAY_i (RGRAY_i),
    .WEN_o   (WEN_o),
    .WADDR_o (WADDR_o),
    .WGRAY_o (WGRAY_o),
`ifdef WPTR_ALMOST_FULL_EN
    .AFULL_o (AFULL_o),
`endif
    .WFULL_o (WFULL_o)
  );

  // clock / reset
  always #5 if (run_clk) CLK_i = ~CLK_i;

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ {1'b0, b[AW:1]};
  endfunction

  task tick;
    @(posedge CLK_i);
    #1;
  endtask

  task do_reset;
    WINC_i = 1'b0;
    RGRAY_i = '0;
    @(negedge CLK_i);
    RST_i = 1'b1;
    @(negedge CLK_i);
    RST_i = 1'b0;
    tick();
    exp_q.delete();
  endtask

  // accepted write: pop the scoreboard and compare the address
  task sb_check_write(input string tag);
    n_checks++;
    if (WEN_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s wen: got %b exp 1", tag, WEN_o);
    end else if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s sb_empty: WEN with no expected write", tag);
    end else begin
      exp_addr = exp_q.pop_front();
      n_checks++;
      if (WADDR_o !== exp_addr) begin
        n_fail++;
        $display("FAIL %s waddr: got %0d exp %0d", tag, WADDR_o, exp_addr);
      end
    end
  endtask

  task test_reset;
    run_clk = 1'b0;
    WINC_i = 1'b0;
    RGRAY_i = '0;
    #2 RST_i = 1'b1;
    #1;
    n_checks++;
    if ({WEN_o, WADDR_o, WGRAY_o, WFULL_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got wen=%b waddr=%0d wgray=%b wfull=%b exp all 0", WEN_o, WADDR_o, WGRAY_o, WFULL_o);
    end
`ifdef WPTR_ALMOST_FULL_EN
    n_checks++;
    if (AFULL_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_afull: got %b exp 0", AFULL_o);
    end
`endif
    RST_i = 1'b0;
    #2 run_clk = 1'b1;
    tick();
    tick();
    n_checks++;
    if (WADDR_o !== 4'd0 || WGRAY_o !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_release: got waddr=%0d wgray=%b exp 0 00000", WADDR_o, WGRAY_o);
    end
    // reset mid-burst with the clock stopped
    WINC_i = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if (WADDR_o !== 4'd3) begin
      n_fail++;
      $display("FAIL burst_pre_reset waddr: got %0d exp 3", WADDR_o);
    end
    @(negedge CLK_i);
    run_clk = 1'b0;
    WINC_i = 1'b0;
    #1 RST_i = 1'b1;
    #1;
    n_checks++;
    if ({WEN_o, WADDR_o, WGRAY_o, WFULL_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_midburst: got wen=%b waddr=%0d wgray=%b wfull=%b exp all 0", WEN_o, WADDR_o, WGRAY_o, WFULL_o);
    end
    RST_i = 1'b0;
    #1 run_clk = 1'b1;
    tick();
  endtask

  task test_fill;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      WINC_i = 1'b1;
      exp_q.push_back(AW'(i));
      #1;
      sb_check_write("fill");
      tick();
      n_checks++;
      if (WGRAY_o !== gray(5'(i + 1)) || WFULL_o !== (i == 15)) begin
        n_fail++;
        $display("FAIL fill_ptr[%0d]: got wgray=%b wfull=%b exp wgray=%b wfull=%b", i, WGRAY_o, WFULL_o, gray(5'(i + 1)), (i == 15));
      end
    end
    n_checks++;
    if (WGRAY_o !== 5'b11000) begin
      n_fail++;
      $display("FAIL fill_final wgray: got %b exp 11000", WGRAY_o);
    end
  endtask

  task test_write_while_full;
    for (int i = 0; i < 4; i++) begin
      WINC_i = 1'b1;
      #1;
      n_checks++;
      if (WEN_o !== 1'b0 || WADDR_o !== 4'd0) begin
        n_fail++;
        $display("FAIL full_drop[%0d]: got wen=%b waddr=%0d exp 0 0", i, WEN_o, WADDR_o);
      end
      tick();
      n_checks++;
      if (WGRAY_o !== 5'b11000 || WFULL_o !== 1'b1) begin
        n_fail++;
        $display("FAIL full_hold[%0d]: got wgray=%b wfull=%b exp 11000 1", i, WGRAY_o, WFULL_o);
      end
    end
  endtask

  task test_drain_release;
    WINC_i = 1'b0;
    RGRAY_i = 5'b00001;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_checks++;
      if (WFULL_o !== (e < 3)) begin
        n_fail++;
        $display("FAIL drain_edge%0d wfull: got %b exp %b", e, WFULL_o, (e < 3));
      end
    end
    WINC_i = 1'b1;
    exp_q.push_back(4'd0);
    #1;
    sb_check_write("drain_write");
    tick();
    WINC_i = 1'b0;
  endtask

  task test_wrap;
    int wcnt;
    int rp;
    do_reset();
    wcnt = 0;
    for (int k = 0; k < 40; k++) begin
      rp = (wcnt >= 4) ? wcnt - 4 : 0;
      RGRAY_i = gray(5'(rp));
      WINC_i = 1'b1;
      exp_q.push_back(AW'(wcnt));
      #1;
      sb_check_write("wrap");
      tick();
      wcnt++;
      n_checks++;
      if (WGRAY_o !== gray(5'(wcnt)) || WFULL_o !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_ptr[%0d]: got wgray=%b wfull=%b exp wgray=%b wfull=0", wcnt, WGRAY_o, WFULL_o, gray(5'(wcnt)));
      end
      if (wcnt == 31) begin
        n_checks++;
        if (WGRAY_o !== 5'b10000) begin
          n_fail++;
          $display("FAIL wrap_top wgray: got %b exp 10000", WGRAY_o);
        end
      end
      if (wcnt == 32) begin
        n_checks++;
        if (WGRAY_o !== 5'b00000 || WADDR_o !== 4'd0) begin
          n_fail++;
          $display("FAIL wrap_zero: got wgray=%b waddr=%0d exp 00000 0", WGRAY_o, WADDR_o);
        end
      end
    end
    WINC_i = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending exp 0", exp_q.size());
    end
  endtask

`ifdef WPTR_ALMOST_FULL_EN
  task test_afull;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      WINC_i = 1'b1;
      exp_q.push_back(AW'(k - 1));
      #1;
      sb_check_write("afull");
      tick();
      n_checks++;
      if (AFULL_o !== (k >= 14) || WFULL_o !== (k >= 16)) begin
        n_fail++;
        $display("FAIL afull_edge%0d: got afull=%b wfull=%b exp afull=%b wfull=%b", k, AFULL_o, WFULL_o, (k >= 14), (k >= 16));
      end
    end
    WINC_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_write_while_full();
    test_drain_release();
    test_wrap();
`ifdef WPTR_ALMOST_FULL_EN
    test_afull();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_ctrl.md
# fifo_wptr_ctrl

Write-side pointer controller for the asynchronous FIFO. It owns the write-domain binary pointer and its Gray-coded image, and synchronizes the read-domain Gray pointer into the write clock. It derives a registered full flag and gates write requests into a RAM write enable. It sits between the write-side client and the dual-port RAM, and drives the Gray pointer that the read-side controller synchronizes.

## Interface
- `ADDR_W`, default 4: RAM address width; pointers are `ADDR_W+1` bits; depth = 2^`ADDR_W`.
- `AF_MARGIN`, default 2: free-slot threshold for almost-full; present only with `WPTR_ALMOST_FULL_EN`.
- `CLK_i` input 1: write-domain clock; all state on rising edge.
- `RST_i` input 1: reset, asynchronous, active-high.
- `WINC_i` input 1: write request from the client.
- `RGRAY_i` input `ADDR_W+1`: read Gray pointer, raw from the read domain (asynchronous).
- `WEN_o` output 1: RAM write enable.
- `WADDR_o` output `ADDR_W`: RAM write address.
- `WGRAY_o` output `ADDR_W+1`: registered write Gray pointer, sent to the read domain.
- `WFULL_o` output 1: registered full flag.
- `AFULL_o` output 1: registered almost-full flag; exists only with `WPTR_ALMOST_FULL_EN`.

## Operation
- Registers:
  - `wbin`, `wgray` (both `ADDR_W+1` bits).
  - Synchronizer stages `rq1`, `rq2`.
  - `WFULL_o`, and `AFULL_o` when enabled.
- Reset: all registers go to 0. `WFULL_o`=0, `AFULL_o`=0, `WADDR_o`=0, `WGRAY_o`=0, `WEN_o`=0.
- `WEN_o` = `WINC_i & ~WFULL_o`. This is combinational and is the only write qualification.
- `wbin_next` = `wbin + WEN_o`, computed modulo 2^(`ADDR_W+1`). The pointer wraps from all-ones to 0 with no special case.
- `wgray_next` = `wbin_next ^ (wbin_next >> 1)`.
- On each edge: `wbin` ← `wbin_next`, `wgray` ← `wgray_next`.
- `WADDR_o` = `wbin[ADDR_W-1:0]`. `WGRAY_o` = `wgray`.
- Synchronizer: on each edge `rq1` ← `RGRAY_i`, then `rq2` ← `rq1`. No other logic reads `RGRAY_i` directly.
- Full: `WFULL_o` ← (`wgray_next` == {~`rq2`[MSB:MSB-1], `rq2`[MSB-2:0]}).
- A write request while full is dropped: `WEN_o`=0 and the pointers hold. No error flag is raised.
- A write and a synchronized read pointer advance in the same cycle are both applied. The full flag is evaluated against the post-write pointer.
- Full is pessimistic, because the read pointer is seen late. The controller never overwrites unread data.

## Timing
- A write accepted at edge N: `WADDR_o` and `WGRAY_o` advance at edge N.
- If that write fills the FIFO, `WFULL_o`=1 from edge N.
- A read pointer change on `RGRAY_i` before edge N: `rq1` updates at N, `rq2` at N+1, and `WFULL_o` is updated at N+2. That is 3 edges including the capture edge.
- Reset assertion clears all state immediately, without waiting for a clock edge. Release must be synchronous to `CLK_i`, which is the integrator's responsibility.
- Reset asserted mid-burst: the pointers return to 0 and the pending write is lost.

## Configuration
- Macro `WPTR_ALMOST_FULL_EN`, when defined:
  - Adds the `AFULL_o` port and the `AF_MARGIN` parameter.
  - `rbin` = Gray-to-binary of `rq2`, computed as a prefix XOR from the MSB down.
  - `level` = `wbin_next - rbin`, computed modulo 2^(`ADDR_W+1`).
  - `AFULL_o` ← (`level` >= 2^`ADDR_W` - `AF_MARGIN`), registered, with the same latency as `WFULL_o`.
- Macro undefined: no `AFULL_o` port, no Gray-to-binary logic, and `AF_MARGIN` is unused.

## Structure
- Shared package `async_fifo_pkg` holds:
  - the default `ADDR_W`;
  - the pointer width `PTR_W` = `ADDR_W+1`;
  - the bin-to-Gray and Gray-to-binary functions, which the read-side controller reuses.
- One sub-module, `sync_2ff`: a parameterized-width two-flop synchronizer with asynchronous active-high reset. It is reused by the read-side controller.

## Test plan
All scenarios use `ADDR_W`=4.
- Reset: assert `RST_i` with no clock running → all outputs 0 immediately; after release, `WADDR_o`=0 and `WGRAY_o`=5'b00000.
- Fill: `RGRAY_i`=0, `WINC_i`=1 for 16 cycles → `WADDR_o` steps 0..15, `WEN_o`=1 throughout; after the 16th edge `WGRAY_o`=5'b11000 and `WFULL_o`=1.
- Write while full: keep `WINC_i`=1 for 4 more cycles → `WEN_o`=0, `WADDR_o` stays 0, `WGRAY_o` stays 5'b11000.
- Drain release: set `RGRAY_i`=5'b00001 (binary 1) → `WFULL_o` falls exactly at the 3rd rising edge; the next write gives `WEN_o`=1 at `WADDR_o`=0.
- Wrap: a model reader keeps `RGRAY_i` trailing by 4 entries while 40 writes are made → `wbin` passes 31→0, `WGRAY_o` goes 5'b10000→5'b00000, and `WFULL_o` is never 1.
- `WPTR_ALMOST_FULL_EN` with `AF_MARGIN`=2, `RGRAY_i`=0 → `AFULL_o`=1 after the 14th write edge; `WFULL_o` stays 0 until the 16th write edge.
